// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with registered master outputs, fill-level and packet counters, and an
// optional store-and-forward mode that falls back to cut-through for packets larger than DEPTH.
module axis_pkt_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int USER_WIDTH  = 128,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic [DATA_WIDTH/8-1:0]      s_tkeep,
    input  logic [USER_WIDTH-1:0]        s_tuser,
    input  logic                         s_tlast,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic [DATA_WIDTH/8-1:0]      m_tkeep,
    output logic [USER_WIDTH-1:0]        m_tuser,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic                         oversize
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DATA_WIDTH + DATA_WIDTH/8 + USER_WIDTH + 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [EW-1:0]  mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  fill_level_r;
    logic [CW-1:0]  pkt_count_r;
    logic           release_r;
    logic           oversize_r;
    logic           s_tready_r;
    logic           m_tvalid_r;
    logic [EW-1:0]  m_beat_r;

    logic           wr_s;
    logic           rd_s;
    logic [PW-1:0]  wr_ptr_nxt_s;
    logic [PW-1:0]  rd_ptr_nxt_s;
    logic [PW-1:0]  fill_nxt_s;
    logic           empty_nxt_s;
    logic           full_nxt_s;
    logic           pkt_inc_s;
    logic           pkt_dec_s;
    logic [CW-1:0]  pkt_nxt_s;
    logic           release_nxt_s;
    logic           set_release_s;
    logic           m_tvalid_nxt_s;
    logic           head_new_s;
    logic [EW-1:0]  s_beat_s;
    logic [EW-1:0]  head_s;

    assign s_beat_s = {s_tdata, s_tkeep, s_tuser, s_tlast};

    // Handshakes, next pointers and occupancy flags
    always_comb begin
        wr_s         = s_tvalid & s_tready_r;
        rd_s         = m_tvalid_r & m_tready;
        wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_s};
        rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, rd_s};
        fill_nxt_s   = wr_ptr_nxt_s - rd_ptr_nxt_s;
        empty_nxt_s  = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s   = (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]) &&
                       (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]);
    end

    // Complete-packet counter: a written tlast adds one, a read tlast removes one
    always_comb begin
        pkt_inc_s = wr_s & s_tlast;
        pkt_dec_s = rd_s & m_tlast;
        case ({pkt_inc_s, pkt_dec_s})
            2'b10:   pkt_nxt_s = pkt_count_r + CNT_ONE;
            2'b01:   pkt_nxt_s = pkt_count_r - CNT_ONE;
            default: pkt_nxt_s = pkt_count_r;
        endcase
    end

    // Oversize release: a full FIFO holding no tlast can never complete its packet
    always_comb begin
        release_nxt_s = 1'b0;
        set_release_s = 1'b0;
        if (PACKET_MODE != 32'sd0) begin
            if (release_r) begin
                if (rd_s && m_tlast) begin
                    release_nxt_s = 1'b0;
                end else begin
                    release_nxt_s = 1'b1;
                end
            end else if (full_nxt_s && (pkt_nxt_s == CNT_ZERO)) begin
                release_nxt_s = 1'b1;
                set_release_s = 1'b1;
            end else begin
                release_nxt_s = 1'b0;
            end
        end else begin
            release_nxt_s = 1'b0;
        end
    end

    // Output-valid policy for the next cycle
    always_comb begin
        m_tvalid_nxt_s = 1'b0;
        if (empty_nxt_s) begin
            m_tvalid_nxt_s = 1'b0;
        end else if (PACKET_MODE == 32'sd0) begin
            m_tvalid_nxt_s = 1'b1;
        end else begin
            m_tvalid_nxt_s = (pkt_nxt_s != CNT_ZERO) || release_nxt_s;
        end
    end

    // Next head beat; a beat written into an empty FIFO is taken straight from the slave port
    always_comb begin
        head_new_s = wr_s && (wr_ptr_r == rd_ptr_nxt_s);
        if (head_new_s) begin
            head_s = s_beat_s;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
        end
    end

    // Storage array write port
    always_ff @(posedge aclk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= s_beat_s;
        end
    end

    // Pointers, counters, release flag and registered port outputs
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fill_level_r <= CNT_ZERO;
            pkt_count_r  <= CNT_ZERO;
            release_r    <= 1'b0;
            oversize_r   <= 1'b0;
            s_tready_r   <= 1'b0;
            m_tvalid_r   <= 1'b0;
            m_beat_r     <= {EW{1'b0}};
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            fill_level_r <= fill_nxt_s;
            pkt_count_r  <= pkt_nxt_s;
            release_r    <= release_nxt_s;
            oversize_r   <= set_release_s;
            s_tready_r   <= !full_nxt_s;
            m_tvalid_r   <= m_tvalid_nxt_s;
            // The head slot is never overwritten while occupied, so a stalled beat stays stable
            if (!empty_nxt_s) begin
                m_beat_r <= head_s;
            end
        end
    end

    assign s_tready   = s_tready_r;
    assign m_tvalid   = m_tvalid_r;
    assign {m_tdata, m_tkeep, m_tuser, m_tlast} = m_beat_r;
    assign fill_level = fill_level_r;
    assign pkt_count  = pkt_count_r;
    assign oversize   = oversize_r;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo: one cut-through and one store-and-forward instance,
// directed scenarios plus a randomised backpressure stream checked beat by beat.
module tb_axis_pkt_fifo;

    localparam int DW = 32;
    localparam int UW = 8;
    localparam int KW = DW / 8;
    localparam int DP = 16;
    localparam int CW = $clog2(DP + 1);

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [1:0]    s_tvalid, s_tlast, s_tready;
    logic [1:0]    m_tvalid, m_tready, m_tlast, oversize;
    logic [DW-1:0] s_tdata [2];
    logic [KW-1:0] s_tkeep [2];
    logic [UW-1:0] s_tuser [2];
    logic [DW-1:0] m_tdata [2];
    logic [KW-1:0] m_tkeep [2];
    logic [UW-1:0] m_tuser [2];
    logic [CW-1:0] fill_level [2];
    logic [CW-1:0] pkt_count [2];

    int    vec_cnt = 0;
    int    err_cnt = 0;
    beat_t exp0_q[$];
    beat_t exp1_q[$];
    int    ov_cnt [2];
    bit    hold_r [2];
    beat_t prev_r [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            axis_pkt_fifo #(
                .DATA_WIDTH (DW),
                .USER_WIDTH (UW),
                .DEPTH      (DP),
                .PACKET_MODE(g)
            ) u_dut (
                .aclk      (clk),
                .areset    (rst),
                .s_tdata   (s_tdata[g]),
                .s_tkeep   (s_tkeep[g]),
                .s_tuser   (s_tuser[g]),
                .s_tlast   (s_tlast[g]),
                .s_tvalid  (s_tvalid[g]),
                .s_tready  (s_tready[g]),
                .m_tdata   (m_tdata[g]),
                .m_tkeep   (m_tkeep[g]),
                .m_tuser   (m_tuser[g]),
                .m_tlast   (m_tlast[g]),
                .m_tvalid  (m_tvalid[g]),
                .m_tready  (m_tready[g]),
                .fill_level(fill_level[g]),
                .pkt_count (pkt_count[g]),
                .oversize  (oversize[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic [UW-1:0] u, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.u = u; b.l = l;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int md, input beat_t b, input logic v);
        s_tdata[md]  = b.d;
        s_tkeep[md]  = b.k;
        s_tuser[md]  = b.u;
        s_tlast[md]  = b.l;
        s_tvalid[md] = v;
    endtask

    task automatic push(input int md, input beat_t b);
        if (md == 0) exp0_q.push_back(b);
        else         exp1_q.push_back(b);
    endtask

    // Present one beat and wait (bounded) until it is accepted; expected beat queued on acceptance.
    task automatic send(input int md, input beat_t b);
        bit acc;
        acc = 1'b0;
        drive(md, b, 1'b1);
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (s_tready[md]) begin
                push(md, b);
                acc = 1'b1;
            end
            tick();
        end
        s_tvalid[md] = 1'b0;
        if (!acc) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL send_timeout: dut%0d beat 0x%0h not accepted", md, b.d);
        end
    endtask

    task automatic drain(input int md);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (fill_level[md] == '0) break;
        end
        chk($sformatf("drain%0d", md), 64'(fill_level[md]), 64'd0);
        tick();
    endtask

    task automatic rand_run(input int md, input int npkt);
        int    p, b, len;
        bit    have, acc;
        logic  vld;
        beat_t cur;
        p = 0; b = 0; have = 1'b0; vld = 1'b0;
        len = $urandom_range(1, 8);
        for (int cyc = 0; cyc < 20000 && p < npkt; cyc++) begin
            if (!have) begin
                cur  = mk(DW'($urandom), KW'($urandom), UW'($urandom), (b == len - 1));
                have = 1'b1;
            end
            if (!vld) vld = ($urandom_range(0, 3) != 0);
            drive(md, cur, vld);
            m_tready[md] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = s_tvalid[md] & s_tready[md];
            if (acc) push(md, cur);
            tick();
            if (acc) begin
                have = 1'b0;
                vld  = 1'b0;
                if (cur.l) begin
                    p++;
                    b   = 0;
                    len = $urandom_range(1, 8);
                end else begin
                    b++;
                end
            end
        end
        s_tvalid[md] = 1'b0;
        m_tready[md] = 1'b1;
        drain(md);
        chk($sformatf("rand_pkts%0d", md), 64'(p), 64'(npkt));
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks AXI-S hold stability.
    always @(negedge clk) begin
        beat_t cur, e;
        for (int md = 0; md < 2; md++) begin
            cur = mk(m_tdata[md], m_tkeep[md], m_tuser[md], m_tlast[md]);
            if (rst) begin
                hold_r[md] = 1'b0;
            end else begin
                if (hold_r[md]) begin
                    chk($sformatf("hold_valid%0d", md), 64'(m_tvalid[md]), 64'd1);
                    chk($sformatf("hold_data%0d", md), 64'(cur), 64'(prev_r[md]));
                end
                if (oversize[md]) begin
                    ov_cnt[md]++;
                    chk($sformatf("oversize_fill%0d", md), 64'(fill_level[md]), 64'(DP));
                end
                if (m_tvalid[md] && m_tready[md]) begin
                    if ((md == 0 && exp0_q.size() == 0) || (md == 1 && exp1_q.size() == 0)) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_beat%0d: got 0x%0h, expected none", md, cur);
                    end else begin
                        e = (md == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                        chk($sformatf("beat%0d", md), 64'(cur), 64'(e));
                    end
                end
                hold_r[md] = m_tvalid[md] & !m_tready[md];
                prev_r[md] = cur;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_base;
        beat_t a;
        clk = 1'b0;
        rst = 1'b1;
        s_tvalid = 2'b00;
        s_tlast  = 2'b00;
        m_tready = 2'b00;
        ov_cnt[0] = 0;
        ov_cnt[1] = 0;
        for (int md = 0; md < 2; md++) drive(md, mk('0, '0, '0, 1'b0), 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int md = 0; md < 2; md++) begin
            chk("rst_tready",   64'(s_tready[md]),   64'd0);
            chk("rst_tvalid",   64'(m_tvalid[md]),   64'd0);
            chk("rst_fill",     64'(fill_level[md]), 64'd0);
            chk("rst_pkt",      64'(pkt_count[md]),  64'd0);
            chk("rst_oversize", 64'(oversize[md]),   64'd0);
            chk("rst_tdata",    64'(m_tdata[md]),    64'd0);
            chk("rst_tlast",    64'(m_tlast[md]),    64'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("tready_deassert_cycle", 64'(s_tready), 64'd0);
        @(negedge clk);
        chk("tready_after_reset", 64'(s_tready), 64'd3);
        tick();

        // T1: reset in the middle of a burst
        m_tready[0] = 1'b0;
        for (int i = 0; i < 5; i++) send(0, mk(DW'(32'h100 + i), 4'hF, UW'(i), 1'b0));
        @(negedge clk);
        chk("t1_fill_pre", 64'(fill_level[0]), 64'd5);
        tick();
        drive(0, mk(32'h1FF, 4'hF, 8'hFF, 1'b1), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t1_fill_rst",   64'(fill_level[0]), 64'd0);
        chk("t1_tvalid_rst", 64'(m_tvalid[0]),   64'd0);
        chk("t1_tready_rst", 64'(s_tready[0]),   64'd0);
        exp0_q.delete();
        exp1_q.delete();
        tick();
        s_tvalid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("t1_tready_deassert", 64'(s_tready[0]), 64'd0);
        @(negedge clk);
        chk("t1_tready_rise", 64'(s_tready[0]), 64'd1);
        chk("t1_fill_after",  64'(fill_level[0]), 64'd0);
        chk("t1_valid_after", 64'(m_tvalid[0]),   64'd0);
        tick();

        // T2: fill to DEPTH with no tlast, mode 0
        for (int i = 0; i < 16; i++) send(0, mk(DW'(i), 4'hF, UW'(i), 1'b0));
        @(negedge clk);
        chk("t2_tready_full", 64'(s_tready[0]),   64'd0);
        chk("t2_fill_full",   64'(fill_level[0]), 64'd16);
        chk("t2_valid_full",  64'(m_tvalid[0]),   64'd1);
        chk("t2_head_data",   64'(m_tdata[0]),    64'd0);
        chk("t2_no_oversize", 64'(oversize[0]),   64'd0);
        tick();

        // T3a: read and attempted write at full -> only the read happens
        m_tready[0] = 1'b1;
        drive(0, mk(32'd100, 4'hF, 8'd100, 1'b0), 1'b1);
        @(negedge clk);
        chk("t3_full_tready", 64'(s_tready[0]),   64'd0);
        chk("t3_full_fill",   64'(fill_level[0]), 64'd16);
        tick();
        s_tvalid[0] = 1'b0;
        @(negedge clk);
        chk("t3_full_fill_after", 64'(fill_level[0]), 64'd15);
        chk("t3_full_ready_after", 64'(s_tready[0]),  64'd1);
        tick();
        drain(0);

        // T3b: write into empty FIFO, no same-cycle bypass
        a = mk(32'hA0A0_0001, 4'h3, 8'h11, 1'b1);
        drive(0, a, 1'b1);
        @(negedge clk);
        chk("t3_empty_valid_wr_cycle", 64'(m_tvalid[0]), 64'd0);
        chk("t3_empty_tready",         64'(s_tready[0]), 64'd1);
        push(0, a);
        tick();
        s_tvalid[0] = 1'b0;
        @(negedge clk);
        chk("t3_empty_valid_next", 64'(m_tvalid[0]),   64'd1);
        chk("t3_empty_fill",       64'(fill_level[0]), 64'd1);
        tick();
        send(0, mk(32'hB0B0_0002, 4'h1, 8'h22, 1'b0));
        send(0, mk(32'hC0C0_0003, 4'h8, 8'h33, 1'b1));
        @(negedge clk);
        chk("t3_rw_fill_const", 64'(fill_level[0]), 64'd1);
        tick();
        drain(0);

        // T4: store-and-forward of a 4-beat packet
        m_tready[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(1, mk(DW'(32'hC000 + k), KW'(k + 1), UW'(k * 3), (k == 3)));
            @(negedge clk);
            chk($sformatf("t4_valid_b%0d", k), 64'(m_tvalid[1]),  64'(k == 3));
            chk($sformatf("t4_pkt_b%0d", k),   64'(pkt_count[1]), 64'(k == 3));
            tick();
        end
        drain(1);
        @(negedge clk);
        chk("t4_pkt_final", 64'(pkt_count[1]), 64'd0);
        tick();

        // T5: 20-beat packet overflows the store-and-forward buffer
        ov_base = ov_cnt[1];
        for (int i = 0; i < 20; i++) send(1, mk(DW'(32'h5000 + i), 4'hF, UW'(i), (i == 19)));
        drain(1);
        chk("t5_oversize_pulses", 64'(ov_cnt[1] - ov_base), 64'd1);
        send(1, mk(32'h6000, 4'h7, 8'h60, 1'b0));
        @(negedge clk);
        chk("t5_release_cleared", 64'(m_tvalid[1]), 64'd0);
        tick();
        send(1, mk(32'h6001, 4'hE, 8'h61, 1'b1));
        @(negedge clk);
        chk("t5_next_pkt_valid", 64'(m_tvalid[1]), 64'd1);
        tick();
        drain(1);

        // T6: random packets with random valid/ready, both modes
        ov_base = ov_cnt[1];
        rand_run(0, 500);
        rand_run(1, 500);
        chk("t6_no_oversize", 64'(ov_cnt[1] - ov_base), 64'd0);
        chk("mode0_never_oversize", 64'(ov_cnt[0]), 64'd0);
        chk("queue0_empty", 64'(exp0_q.size()), 64'd0);
        chk("queue1_empty", 64'(exp1_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
